// File: rtl/tl45_wb_sram_slave_if.sv
// Wishbone B4 pipelined bus between tl45_memory (master) and the SRAM slave.
interface tl45_wb_sram_slave_if #(
  parameter int AW = 30
);
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [AW-1:0] i_wb_addr;
  logic [31:0]   i_wb_data;
  logic [3:0]    i_wb_sel;
  logic          o_wb_ack;
  logic          o_wb_stall;
  logic          o_wb_err;
  logic [31:0]   o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_ack, o_wb_stall, o_wb_err, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_ack, o_wb_stall, o_wb_err, o_wb_data
  );
endinterface

// File: rtl/tl45_wb_sram_slave.sv
// Wishbone pipelined slave over an on-chip word store: byte-lane writes,
// in-order ack/err at a fixed latency, optional zero-fill after reset.
module tl45_wb_sram_slave #(
  parameter int            AW         = 30,
  parameter int            DEPTH_LOG2 = 12,
  parameter logic [AW-1:0] BASE       = '0,
  parameter int            READ_LAT   = 1,
  parameter bit            OPT_CLEAR  = 1'b1
) (
  input logic                 i_clk,
  input logic                 i_reset_n,
  tl45_wb_sram_slave_if.slave wb
);
  // state | meaning
  // CLEAR | zero-filling the RAM one word per cycle, bus stalled
  // READY | accepting one request per cycle, no back-pressure
  typedef enum logic {CLEAR, READY} state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] clr_addr;
  logic                  clr_last;
  logic [31:0]           mem [DEPTH];
  logic                  accept;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [READ_LAT-1:0]   pipe_vld;
  logic [READ_LAT-1:0]   pipe_err;
  logic [31:0]           pipe_data [READ_LAT];

  assign clr_last = (clr_addr == {DEPTH_LOG2{1'b1}});
  assign ram_idx  = wb.i_wb_addr[DEPTH_LOG2-1:0];
  assign in_range = (wb.i_wb_addr[AW-1:DEPTH_LOG2] == BASE[AW-1:DEPTH_LOG2]);
  assign accept   = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_stall;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= OPT_CLEAR ? CLEAR : READY;
    else            state <= state_next;
  end

  always_comb begin
    state_next    = state;
    wb.o_wb_stall = 1'b0;
    case (state)
      CLEAR: begin
        wb.o_wb_stall = 1'b1;
        if (clr_last) state_next = READY;
      end
      READY: state_next = READY;
      default: state_next = READY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)          clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
  end

  // RAM contents deliberately have no reset; the zero-fill pass covers it.
  always_ff @(posedge i_clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (accept && wb.i_wb_we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.i_wb_sel[b]) mem[ram_idx][8*b +: 8] <= wb.i_wb_data[8*b +: 8];
      end
    end
  end

  // A write committed at the previous edge is already in mem, so the
  // asynchronous read here is write-first for back-to-back requests.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int k = 0; k < READ_LAT; k++) pipe_data[k] <= '0;
    end else if (!wb.i_wb_cyc) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0]  <= accept;
      pipe_err[0]  <= accept & ~in_range;
      pipe_data[0] <= (accept && !wb.i_wb_we && in_range) ? mem[ram_idx] : 32'h0;
      for (int k = 1; k < READ_LAT; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_err[k]  <= pipe_err[k-1];
        pipe_data[k] <= pipe_data[k-1];
      end
    end
  end

  assign wb.o_wb_ack  = wb.i_wb_cyc & pipe_vld[READ_LAT-1] & ~pipe_err[READ_LAT-1];
  assign wb.o_wb_err  = wb.i_wb_cyc & pipe_vld[READ_LAT-1] & pipe_err[READ_LAT-1];
  assign wb.o_wb_data = wb.o_wb_ack ? pipe_data[READ_LAT-1] : 32'h0;
endmodule

// File: tb/tb_tl45_wb_sram_slave.sv
// Directed bench for tl45_wb_sram_slave: 16-word RAM, two-cycle response latency.
module tb_tl45_wb_sram_slave;
  localparam int AW = 30;
  localparam int DL = 4;
  localparam int RL = 2;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  tl45_wb_sram_slave_if #(.AW(AW)) bus();

  tl45_wb_sram_slave #(
    .AW(AW), .DEPTH_LOG2(DL), .BASE(30'h0), .READ_LAT(RL), .OPT_CLEAR(1'b1)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .wb(bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.i_wb_cyc  = 1'b0;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = '0;
    bus.i_wb_data = '0;
    bus.i_wb_sel  = '0;
  endtask

  task automatic reset_release(input string tag);
    int n;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    check({tag, "_stall_at_release"}, bus.o_wb_stall, 1);
    n = 0;
    do begin
      @(posedge i_clk); #1;
      n++;
    end while (bus.o_wb_stall && n < 100);
    check({tag, "_stall_cycles"}, n, 16);
  endtask

  task automatic wb_single(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] sel, output logic ack, output logic err,
                           output logic [31:0] rdata, output int lat);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_wb_addr = addr;
    bus.i_wb_data = data;
    bus.i_wb_sel  = sel;
    ack = 1'b0; err = 1'b0; rdata = '0; lat = 0;
    while (!(ack || err) && lat < 10) begin
      @(posedge i_clk); #1;
      lat++;
      bus.i_wb_stb = 1'b0;
      if (bus.o_wb_ack || bus.o_wb_err) begin
        ack = bus.o_wb_ack; err = bus.o_wb_err; rdata = bus.o_wb_data;
      end
    end
    bus_idle();
    @(posedge i_clk); #1;
  endtask

  task automatic wb_write(input string tag, input logic [AW-1:0] addr,
                          input logic [31:0] data, input logic [3:0] sel);
    logic ack, err; logic [31:0] rd; int lat;
    wb_single(1'b1, addr, data, sel, ack, err, rd, lat);
    check({tag, "_ack"}, ack, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_lat"}, lat, RL);
  endtask

  task automatic wb_read(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp);
    logic ack, err; logic [31:0] rd; int lat;
    wb_single(1'b0, addr, 32'h0, 4'hF, ack, err, rd, lat);
    check({tag, "_ack"}, ack, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_data"}, rd, exp);
    check({tag, "_lat"}, lat, RL);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ack, err, seen;
    logic [31:0] rd;
    int lat;
    logic [31:0] exp_w;

    bus_idle();
    i_reset_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ack", bus.o_wb_ack, 0);
    check("rst_err", bus.o_wb_err, 0);
    check("rst_data", bus.o_wb_data, 0);
    check("rst_stall", bus.o_wb_stall, 1);
    reset_release("boot");
    wb_read("zero5", 30'd5, 32'h0);

    wb_write("w_full", 30'd3, 32'hDEADBEEF, 4'b1111);
    wb_write("w_lane0", 30'd3, 32'h000000AA, 4'b0001);
    wb_read("r_lane0", 30'd3, 32'hDEADBEAA);
    wb_write("w_lane3", 30'd3, 32'h11000000, 4'b1000);
    wb_read("r_lane3", 30'd3, 32'h11ADBEAA);
    wb_write("w_nosel", 30'd3, 32'hFFFFFFFF, 4'b0000);
    wb_read("r_nosel", 30'd3, 32'h11ADBEAA);

    for (int i = 0; i < 4; i++) wb_write("preload", 30'(i), 32'h10 + 32'(i), 4'hF);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = 30'd0;
    for (int i = 0; i < 7; i++) begin
      @(posedge i_clk); #1;
      if (i + 1 < 4) bus.i_wb_addr = 30'(i + 1);
      else           bus.i_wb_stb = 1'b0;
      check($sformatf("burst_ack%0d", i), bus.o_wb_ack, (i >= 1 && i <= 4));
      exp_w = (i >= 1 && i <= 4) ? 32'h10 + 32'(i - 1) : 32'h0;
      check($sformatf("burst_data%0d", i), bus.o_wb_data, exp_w);
    end
    bus_idle();
    @(posedge i_clk); #1;

    wb_single(1'b1, 30'd16, 32'hFFFFFFFF, 4'hF, ack, err, rd, lat);
    check("oob_w_err", err, 1);
    check("oob_w_ack", ack, 0);
    check("oob_w_data", rd, 0);
    check("oob_w_lat", lat, RL);
    wb_single(1'b0, 30'h25, 32'h0, 4'hF, ack, err, rd, lat);
    check("oob_r_err", err, 1);
    check("oob_r_ack", ack, 0);
    for (int i = 0; i < 16; i++) begin
      exp_w = (i < 4) ? 32'h10 + 32'(i) : 32'h0;
      wb_read($sformatf("scan%0d", i), 30'(i), exp_w);
    end

    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'd2;
    @(posedge i_clk); #1;
    bus_idle();
    @(posedge i_clk); #1;
    bus.i_wb_cyc = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge i_clk); #1;
      if (bus.o_wb_ack || bus.o_wb_err) seen = 1'b1;
    end
    bus_idle();
    check("drop_no_resp", seen, 0);
    @(posedge i_clk); #1;
    wb_read("after_drop", 30'd1, 32'h11);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = 30'd7;
    bus.i_wb_data = 32'hCAFEF00D;
    bus.i_wb_sel  = 4'hF;
    @(posedge i_clk); #1;
    bus_idle();
    repeat (3) @(posedge i_clk);
    #1;
    wb_read("drop_write", 30'd7, 32'hCAFEF00D);

    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = 30'd9;
    bus.i_wb_data = 32'h5A5A5A5A;
    bus.i_wb_sel  = 4'hF;
    @(posedge i_clk); #1;
    bus.i_wb_we = 1'b0;
    @(posedge i_clk); #1;
    bus.i_wb_stb = 1'b0;
    check("wf_write_ack", bus.o_wb_ack, 1);
    @(posedge i_clk); #1;
    check("wf_read_ack", bus.o_wb_ack, 1);
    check("wf_read_data", bus.o_wb_data, 32'h5A5A5A5A);
    bus_idle();
    @(posedge i_clk); #1;

    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 30'd1;
    @(posedge i_clk); #1;
    bus.i_wb_stb = 1'b0;
    @(posedge i_clk); #1;
    check("pre_rst_ack", bus.o_wb_ack, 1);
    check("pre_rst_data", bus.o_wb_data, 32'h11);
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_read_ack", bus.o_wb_ack, 0);
    check("rst_read_err", bus.o_wb_err, 0);
    check("rst_read_data", bus.o_wb_data, 0);
    check("rst_read_stall", bus.o_wb_stall, 1);
    bus_idle();
    repeat (2) @(posedge i_clk);
    reset_release("rst_mid_read");

    i_reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    reset_release("rst_pre");
    i_reset_n = 1'b1;
    wb_read("still_clear", 30'd1, 32'h0);
    i_reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    check("mid_clear_stall", bus.o_wb_stall, 1);
    i_reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    reset_release("rst_mid_clear");
    wb_read("cleared0", 30'd0, 32'h0);
    wb_read("cleared7", 30'd7, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
